// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder time-sharing controller.
package adder_share_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int ID_W      = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic [ID_W-1:0] other_id(input logic [ID_W-1:0] id);
      return ~id;
   endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle for adder_share_ctrl.
// ADDSHARE_SUB_EN adds the per-requester subtract selects.
interface adder_share_ctrl_if #(parameter int WIDTH = 32);

   logic                           req0_valid;
   logic                           req0_ready;
   logic [WIDTH-1:0]               req0_a;
   logic [WIDTH-1:0]               req0_b;
   logic                           req1_valid;
   logic                           req1_ready;
   logic [WIDTH-1:0]               req1_a;
   logic [WIDTH-1:0]               req1_b;
`ifdef ADDSHARE_SUB_EN
   logic                           req0_sub;
   logic                           req1_sub;
`endif
   logic                           resp_valid;
   logic                           resp_ready;
   logic [adder_share_pkg::ID_W-1:0] resp_id;
   logic [WIDTH-1:0]               resp_sum;
   logic                           resp_carry;
   logic                           busy;

`ifdef ADDSHARE_SUB_EN
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_sum, resp_carry, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_sum, resp_carry, busy
   );
`else
   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_sum, resp_carry, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_sum, resp_carry, busy
   );
`endif

endinterface

// File: rtl/adder_rr_arb.sv
// Two-way round-robin grant; the pointer register lives in the parent.
module adder_rr_arb (
   input  logic valid0,
   input  logic valid1,
   input  logic ptr,
   output logic grant,
   output logic grant_valid
);

   // lone requester wins outright; on contention the pointer decides
   always_comb begin
      grant_valid = valid0 | valid1;
      if (valid0 && valid1) begin
         grant = ptr;
      end else begin
         grant = valid1;
      end
   end

endmodule

// File: rtl/rippleAdder_32bit.sv
// Existing 32-bit ripple-carry adder from the datapath library.
module rippleAdder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [32:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[32];

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one rippleAdder_32bit between two requesters.
// Operands are registered and held on the adder for SETTLE cycles before
// the sum is captured, so the ripple path never feeds a register directly.
// ADDSHARE_SUB_EN: adds per-request subtract (b inverted, carry-in 1).
module adder_share_ctrl
   import adder_share_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   adder_share_ctrl_if.slave  bus
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   if (SETTLE < 1) begin : g_bad_settle
      $error("adder_share_ctrl: SETTLE must be at least 1");
   end
   if (WIDTH != 32) begin : g_bad_width
      $error("adder_share_ctrl: WIDTH must match the 32-bit adder");
   end

   state_t             state;
   logic               ptr;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [ID_W-1:0]    op_id;
   logic               resp_valid_q;
   logic [ID_W-1:0]    resp_id_q;
   logic [WIDTH-1:0]   resp_sum_q;
   logic               resp_carry_q;
   logic               busy_q;

   logic               grant;
   logic               grant_valid;
   logic [WIDTH-1:0]   add_b;
   logic               add_cin;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   adder_rr_arb u_arb (
      .valid0      (bus.req0_valid),
      .valid1      (bus.req1_valid),
      .ptr         (ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // ready only when idle, out of reset, and this requester holds the grant
   assign bus.req0_ready = rst_n && (state == ST_IDLE) && grant_valid && (grant == 1'b0);
   assign bus.req1_ready = rst_n && (state == ST_IDLE) && grant_valid && (grant == 1'b1);

`ifdef ADDSHARE_SUB_EN
   logic op_sub;

   assign add_b   = op_b ^ {WIDTH{op_sub}};
   assign add_cin = op_sub;
`else
   assign add_b   = op_b;
   assign add_cin = 1'b0;
`endif

   rippleAdder_32bit u_adder (
      .a    (op_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // accept -> hold operands for SETTLE cycles -> present result until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         ptr          <= 1'b0;
         cnt          <= '0;
         op_a         <= '0;
         op_b         <= '0;
         op_id        <= '0;
`ifdef ADDSHARE_SUB_EN
         op_sub       <= 1'b0;
`endif
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_sum_q   <= '0;
         resp_carry_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  op_a   <= grant ? bus.req1_a : bus.req0_a;
                  op_b   <= grant ? bus.req1_b : bus.req0_b;
`ifdef ADDSHARE_SUB_EN
                  op_sub <= grant ? bus.req1_sub : bus.req0_sub;
`endif
                  op_id  <= grant;
                  cnt    <= CNT_W'(SETTLE - 1);
                  ptr    <= other_id(grant);
                  state  <= ST_SETTLE;
                  busy_q <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (cnt == '0) begin
                  resp_sum_q   <= add_sum;
                  resp_carry_q <= add_cout;
                  resp_id_q    <= op_id;
                  resp_valid_q <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= ST_IDLE;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_sum   = resp_sum_q;
   assign bus.resp_carry = resp_carry_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl. Build with ADDSHARE_SUB_EN defined
// to also exercise subtraction.
module tb_adder_share_ctrl;
   import adder_share_pkg::*;

   localparam int WIDTH  = 32;
   localparam int SETTLE = 2;

   typedef struct {
      logic        id;
      logic [31:0] sum;
      logic        carry;
      int          accept_edge;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   adder_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

   adder_share_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb[$];
   exp_t got[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cycle = 0;
   int   n_resp = 0;
   bit   mon_en = 1'b0;
   bit   ptr_m = 1'b0;
   bit   done0, done1;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference arithmetic: addition modulo 2^32 with carry, or a-b with carry = no borrow
   function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input int ae);
      exp_t        e;
      logic [32:0] full;
      e.id = id;
      e.accept_edge = ae;
      if (sub) begin
         e.sum   = a - b;
         e.carry = (a >= b);
      end else begin
         full    = {1'b0, a} + {1'b0, b};
         e.sum   = full[31:0];
         e.carry = full[32];
      end
      return e;
   endfunction

   // request side: expected readys/busy from a one-in-flight round-robin model; push on accept
   initial begin
      bit idle, v0, v1, any, g, s0, s1;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            idle = (sb.size() == 0);
            v0   = bus.req0_valid;
            v1   = bus.req1_valid;
            any  = v0 | v1;
            g    = (v0 && v1) ? ptr_m : v1;
            check("req0_ready", bus.req0_ready, rst_n && idle && any && !g);
            check("req1_ready", bus.req1_ready, rst_n && idle && any && g);
            if (!rst_n) begin
               sb.delete();
               ptr_m = 1'b0;
            end else begin
               check("busy", bus.busy, !idle);
               s0 = 1'b0;
               s1 = 1'b0;
`ifdef ADDSHARE_SUB_EN
               s0 = bus.req0_sub;
               s1 = bus.req1_sub;
`endif
               if (v0 && bus.req0_ready) begin
                  sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, s0, cycle + 1));
                  ptr_m = 1'b1;
               end else if (v1 && bus.req1_ready) begin
                  sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, s1, cycle + 1));
                  ptr_m = 1'b0;
               end
            end
         end
      end
   end

   // response side: valid timing, held values, pop on handshake
   initial begin
      exp_t e;
      bit   due;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && rst_n) begin
            if (sb.size() == 0) begin
               check("resp_valid_idle", bus.resp_valid, 1'b0);
            end else begin
               e   = sb[0];
               due = (cycle >= e.accept_edge + SETTLE);
               check("resp_valid", bus.resp_valid, due);
               if (due) begin
                  check("resp_id", bus.resp_id, e.id);
                  check("resp_sum", bus.resp_sum, e.sum);
                  check("resp_carry", bus.resp_carry, e.carry);
                  if (bus.resp_valid && bus.resp_ready) begin
                     void'(sb.pop_front());
                     got.push_back(e);
                     n_resp++;
                  end
               end
            end
         end
      end
   end

   // caller is just after a rising edge; returns just after the accepting edge
   task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
      int  t;
      bit  rdy;
      t = 0;
      if (id == 0) begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
      end
`ifdef ADDSHARE_SUB_EN
      if (id == 0) bus.req0_sub = sub; else bus.req1_sub = sub;
`else
      if (sub) check("sub_unsupported", 1, 0);
`endif
      rdy = 1'b0;
      while (!rdy && t < 400) begin
         @(negedge clk);
         rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
         t++;
      end
      if (!rdy) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
   endtask

   task automatic wait_resp(input int n);
      int t;
      t = 0;
      while (n_resp < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (n_resp < n) check("resp_timeout", n_resp, n);
      @(posedge clk);
      #1;
   endtask

   task automatic post_edge(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_requester(input int id, input int nops, output bit done);
      logic [31:0] a, b;
      logic        sub;
      for (int k = 0; k < nops; k++) begin
         post_edge($urandom_range(0, 3));
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
         b = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom();
`ifdef ADDSHARE_SUB_EN
         sub = 1'($urandom_range(0, 1));
`else
         sub = 1'b0;
`endif
         send(id, a, b, sub);
      end
      done = 1'b1;
   endtask

   initial begin
      int base;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
`ifdef ADDSHARE_SUB_EN
      bus.req0_sub = 1'b0; bus.req1_sub = 1'b0;
`endif
      bus.resp_ready = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_id", bus.resp_id, 0);
      check("rst_resp_sum", bus.resp_sum, 0);
      check("rst_resp_carry", bus.resp_carry, 0);
      check("rst_busy", bus.busy, 0);
      post_edge(1);

      base = n_resp;
      send(0, 32'd5, 32'd9, 1'b0);
      wait_resp(base + 1);
      check("t1_sum", got[base].sum, 14);
      check("t1_carry", got[base].carry, 0);
      check("t1_id", got[base].id, 0);

      base = n_resp;
      send(1, 32'd111124, 32'd862164, 1'b0);
      wait_resp(base + 1);
      check("t2_sum", got[base].sum, 973288);
      check("t2_id", got[base].id, 1);

      base = n_resp;
      fork
         begin send(0, 32'd151241, 32'd9, 1'b0); send(0, 32'd10, 32'd20, 1'b0); end
         begin send(1, 32'd24221, 32'd3214, 1'b0); send(1, 32'd7, 32'd8, 1'b0); end
      join
      wait_resp(base + 4);
      check("t3_id0", got[base].id, 0);
      check("t3_sum0", got[base].sum, 151250);
      check("t3_id1", got[base + 1].id, 1);
      check("t3_sum1", got[base + 1].sum, 27435);
      check("t3_id2", got[base + 2].id, 0);
      check("t3_sum2", got[base + 2].sum, 30);
      check("t3_id3", got[base + 3].id, 1);
      check("t3_sum3", got[base + 3].sum, 15);

      base = n_resp;
      bus.resp_ready = 1'b0;
      send(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      fork
         send(1, 32'd3, 32'd4, 1'b0);
         begin
            int t;
            t = 0;
            while (!bus.resp_valid && t < 50) begin @(negedge clk); t++; end
            check("bp_valid_seen", bus.resp_valid, 1);
            repeat (5) begin
               @(negedge clk);
               check("bp_sum", bus.resp_sum, 0);
               check("bp_carry", bus.resp_carry, 1);
               check("bp_ready0", bus.req0_ready, 0);
               check("bp_ready1", bus.req1_ready, 0);
            end
            @(posedge clk);
            #1 bus.resp_ready = 1'b1;
         end
      join
      wait_resp(base + 2);
      check("bp_id_after", got[base + 1].id, 1);
      check("bp_sum_after", got[base + 1].sum, 7);

      send(0, 32'd100, 32'd200, 1'b0);
      post_edge(1);
      rst_n = 1'b0;
      post_edge(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_resp_valid", bus.resp_valid, 0);
      check("abort_busy", bus.busy, 0);
      post_edge(10);
      base = n_resp;
      fork
         send(1, 32'd1, 32'd2, 1'b0);
         send(0, 32'd3, 32'd4, 1'b0);
      join
      wait_resp(base + 2);
      check("abort_ptr_first", got[base].id, 0);
      check("abort_ptr_second", got[base + 1].id, 1);

`ifdef ADDSHARE_SUB_EN
      base = n_resp;
      send(0, 32'd9, 32'd5, 1'b1);
      wait_resp(base + 1);
      check("sub_sum_pos", got[base].sum, 4);
      check("sub_carry_pos", got[base].carry, 1);
      send(0, 32'd5, 32'd9, 1'b1);
      wait_resp(base + 2);
      check("sub_sum_neg", got[base + 1].sum, 64'hFFFF_FFFC);
      check("sub_carry_neg", got[base + 1].carry, 0);
`endif

      done0 = 1'b0;
      done1 = 1'b0;
      fork
         rand_requester(0, 40, done0);
         rand_requester(1, 40, done1);
         begin
            while (!(done0 && done1)) begin
               @(posedge clk);
               #1 bus.resp_ready = ($urandom_range(0, 3) != 0);
            end
            bus.resp_ready = 1'b1;
         end
      join
      begin
         int t;
         t = 0;
         while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
         check("drain", sb.size(), 0);
      end
      post_edge(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Controller that time-shares one `rippleAdder_32bit` instance between two requesters. It arbitrates round-robin and captures the granted operands. It holds them on the adder for a programmable settle window, then presents the registered sum and carry on a valid/ready response port tagged with the requester ID. It sits between the two operand producers in the datapath and the single 32-bit ripple-carry adder, replacing ad-hoc direct drive of the adder inputs.

## Interface
- `WIDTH`, 32, operand/sum width; must match the adder instance.
- `SETTLE`, 2, cycles operands are held on the adder before the result is captured. Must be ≥1; 0 is an elaboration error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 transfer accepted this edge when both are high.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_sub`  in  1  requester 0 subtract select. Present only with `ADDSHARE_SUB_EN`.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`  as above, for requester 1.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  1  requester that issued this result.
- `resp_sum`  out  WIDTH  registered adder sum.
- `resp_carry`  out  1  registered adder carry-out.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = the valid requester if only one is valid; `ptr` if both are valid.
  - `reqN_ready` = (state==IDLE) && grant==N. It is combinational and may depend on the other requester's valid.
  - On a handshake: capture a, b, sub and id into operand registers, set `cnt`=SETTLE-1, set `ptr` to the other requester, go to SETTLE.
- SETTLE:
  - The adder inputs are driven only from the operand registers.
  - If `cnt`==0: latch adder sum/carry into `resp_sum`/`resp_carry`, set `resp_valid`, go to RESP.
  - Otherwise decrement `cnt`.
- RESP:
  - Hold all `resp_*` stable until `resp_valid && resp_ready`, then clear `resp_valid` and go to IDLE.
  - No new request is accepted in the same edge.
- Arithmetic:
  - Sum is modulo 2^WIDTH.
  - Carry is the adder carry-out, with no sign interpretation.
  - Adder carry-in is tied 0 unless `ADDSHARE_SUB_EN` is defined.
- Reset values, while `rst_n`=0 at an edge:
  - state=IDLE, `ptr`=0, `cnt`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_sum`=0, `resp_carry`=0, `busy`=0.
  - Operand registers=0.
  - Both readys are 0 during the reset cycle.
- Reset mid-operation discards the in-flight operation. No response is ever produced for it.
- A requester that is not granted keeps its valid asserted. It is guaranteed service on the next IDLE grant.

## Timing
- Accept at edge E0. `resp_valid` is visible after edge E0+SETTLE.
- With `resp_ready`=1, the response handshake occurs at edge E0+SETTLE+1 and the next accept at E0+SETTLE+2.
- Peak throughput is one operation per SETTLE+2 cycles.
- Both requesters continuously valid: grants alternate 0,1,0,1,… starting with 0 after reset.
- Backpressure: `resp_valid` stays high indefinitely while `resp_ready`=0. No request is accepted meanwhile.
- `SETTLE` must cover the adder's ripple delay in clock periods; the block performs no combinational capture.

## Configuration
- `ADDSHARE_SUB_EN` defined:
  - `reqN_sub` ports exist and are captured with the operands.
  - With sub=1, the adder sees b inverted and cin=1, giving a−b; carry=1 means no borrow.
- `ADDSHARE_SUB_EN` undefined:
  - `reqN_sub` ports are absent, adder b passes through, cin=0.
  - Behaviour is otherwise identical.

## Structure
- Package `adder_share_pkg`:
  - FSM state typedef (IDLE/SETTLE/RESP).
  - Default `WIDTH` constant.
  - Requester-ID width constant.
- Sub-module `adder_rr_arb`: 2-way round-robin grant from (valid0, valid1, ptr) → (grant, grant_valid), purely combinational. `ptr` stays in the parent.
- The parent instantiates `rippleAdder_32bit` directly; it is not re-implemented.

## Test plan
- req0 only, a=5, b=9, SETTLE=2 → `resp_sum`=14, carry=0, id=0, `resp_valid` rises 2 edges after accept.
- req1 only, a=111124, b=862164 → sum=973288, carry=0, id=1.
- req0 and req1 valid on the same cycle with (151241,9) and (24221,3214) → first response id=0 sum=151250, second id=1 sum=27435; a third back-to-back pair is granted to 0 again only after 1.
- a=0xFFFFFFFF, b=1, `resp_ready` held 0 for 5 cycles → sum=0, carry=1 stable throughout; both `reqN_ready` stay 0 until the response handshake.
- Deassert `rst_n` during SETTLE → next cycle state IDLE, `resp_valid`=0, `busy`=0; no response ever appears for the aborted operation.
- With `ADDSHARE_SUB_EN`, req0 a=9, b=5, sub=1 → sum=4, carry=1; a=5, b=9, sub=1 → sum=0xFFFFFFFC, carry=0.
